// File: rtl/tb_obi_ram_arbiter_if.sv
// tb_obi_ram_arbiter_if: OBI request/response channel between one core port and the RAM arbiter
//   master: core side, drives req/addr/we/be/wdata, receives gnt/rvalid/rdata
//   slave:  arbiter side, the mirror image
interface tb_obi_ram_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave(input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/tb_obi_ram_arbiter.sv
// tb_obi_ram_arbiter: round-robin share of one single-port RAM between the OBI fetch and data ports
//   clk_i, rst_i      clock, async active-high reset
//   instr, data       OBI slave ports (instr ignores we/be/wdata)
//   ram_*             single-port RAM drive, ram_rdata_i valid the cycle after ram_en_o
//   conflict_cnt_o    saturating count of cycles with both requests high
module tb_obi_ram_arbiter #(
  parameter int          ADDR_WIDTH = 22,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  tb_obi_ram_arbiter_if.slave     instr,
  tb_obi_ram_arbiter_if.slave     data,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-3:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [3:0]              ram_be_o,
  output logic [31:0]             ram_wdata_o,
  input  logic [31:0]             ram_rdata_i,
  output logic [31:0]             conflict_cnt_o
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;
  owner_e      last_q, rsp_owner_q, win;
  logic        rsp_valid_q, rsp_we_q;
  logic [15:0] lfsr_q;
  logic [31:0] conflict_cnt_q;
  logic        stall, gnt_i, gnt_d, unused_bits;
  assign stall = STALL_EN && (lfsr_q[1:0] == 2'b11);
  // data wins unless instr also requests and data was the last winner
  assign gnt_d = !rst_i && !stall && data.req && (!instr.req || last_q == OWN_INSTR);
  assign gnt_i = !rst_i && !stall && instr.req && !gnt_d;
  assign win   = gnt_d ? OWN_DATA : OWN_INSTR;
  assign instr.gnt = gnt_i;
  assign data.gnt  = gnt_d;
  assign ram_en_o    = gnt_i || gnt_d;
  assign ram_addr_o  = gnt_d ? data.addr[ADDR_WIDTH-1:2] : gnt_i ? instr.addr[ADDR_WIDTH-1:2] : '0;
  assign ram_we_o    = gnt_d && data.we;
  assign ram_be_o    = gnt_d ? data.be : gnt_i ? 4'hF : 4'h0;
  assign ram_wdata_o = gnt_d ? data.wdata : 32'h0;
  assign instr.rvalid = rsp_valid_q && rsp_owner_q == OWN_INSTR;
  assign data.rvalid  = rsp_valid_q && rsp_owner_q == OWN_DATA;
  // write responses carry no data
  assign instr.rdata = (instr.rvalid && !rsp_we_q) ? ram_rdata_i : 32'h0;
  assign data.rdata  = (data.rvalid && !rsp_we_q) ? ram_rdata_i : 32'h0;
  assign conflict_cnt_o = conflict_cnt_q;
  assign unused_bits = ^{instr.we, instr.be, instr.wdata, instr.addr[1:0], data.addr[1:0],
                         instr.addr[31:ADDR_WIDTH], data.addr[31:ADDR_WIDTH]};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      last_q         <= OWN_INSTR;
      rsp_valid_q    <= 1'b0;
      rsp_owner_q    <= OWN_INSTR;
      rsp_we_q       <= 1'b0;
      lfsr_q         <= SEED;
      conflict_cnt_q <= 32'h0;
    end else begin
      if (ram_en_o) last_q <= win;
      rsp_valid_q <= ram_en_o;
      rsp_owner_q <= win;
      rsp_we_q    <= ram_we_o;
      // Fibonacci taps 16,14,13,11
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (instr.req && data.req && conflict_cnt_q != 32'hFFFF_FFFF) conflict_cnt_q <= conflict_cnt_q + 32'h1;
    end
endmodule

// File: tb/tb_tb_obi_ram_arbiter.sv
// tb_tb_obi_ram_arbiter: randomized self-checking bench for tb_obi_ram_arbiter against a behavioural model
module tb_tb_obi_ram_arbiter;
  localparam int AW = 22;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  tb_obi_ram_arbiter_if ib();
  tb_obi_ram_arbiter_if db();
  tb_obi_ram_arbiter_if sib();
  tb_obi_ram_arbiter_if sdb();
  logic          ram_en, ram_we, s_en, s_we;
  logic [AW-3:0] ram_addr, s_addr;
  logic [3:0]    ram_be, s_be;
  logic [31:0]   ram_wdata, ram_rdata, cnt, s_wdata, s_cnt;
  logic [31:0]   s_rdata = 32'h0;
  tb_obi_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .instr(ib), .data(db),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .conflict_cnt_o(cnt));
  tb_obi_ram_arbiter #(.ADDR_WIDTH(AW), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) sdut (
    .clk_i(clk), .rst_i(rst), .instr(sib), .data(sdb),
    .ram_en_o(s_en), .ram_addr_o(s_addr), .ram_we_o(s_we), .ram_be_o(s_be),
    .ram_wdata_o(s_wdata), .ram_rdata_i(s_rdata), .conflict_cnt_o(s_cnt));
  logic [31:0] mem [0:4095];
  logic [31:0] shadow [0:4095];
  always @(posedge clk)
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we && ram_be[b]) mem[ram_addr[11:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= mem[ram_addr[11:0]];
    end
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  function automatic logic [31:0] init_word(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {~v, v ^ 16'hA5A5};
  endfunction
  logic [15:0] ref_lfsr;
  always @(posedge clk or posedge rst)
    if (rst) ref_lfsr <= 16'hACE1;
    else ref_lfsr <= lfsr_next(ref_lfsr);
  int checks = 0;
  int errors = 0;
  logic        m_last;
  logic [31:0] m_cnt;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                      input logic dwe, input logic [3:0] dbe, input logic [31:0] dwd, output logic [1:0] og);
    logic        gi, gd;
    logic [19:0] idx;
    logic [31:0] rsp, w;
    ib.req = ir; ib.addr = ia;
    db.req = dr; db.addr = da; db.we = dwe; db.be = dbe; db.wdata = dwd;
    #1;
    gd  = dr && (!ir || m_last == 1'b0);
    gi  = ir && !gd;
    idx = 20'(((gd ? da : gi ? ia : 32'h0) >> 2) % (32'h1 << (AW - 2)));
    og  = {ib.gnt, db.gnt};
    check("gnt", og, {gi, gd});
    check("ram", {ram_en, ram_we, ram_be, ram_addr, ram_wdata},
          {gi | gd, gd & dwe, gd ? dbe : gi ? 4'hF : 4'h0, idx, gd ? dwd : 32'h0});
    check("stall_gnt", sib.gnt, ref_lfsr[1:0] != 2'b11);
    w   = shadow[idx[11:0]];
    rsp = (gd && dwe) ? 32'h0 : w;
    if (gd && dwe) begin
      for (int b = 0; b < 4; b++) if (dbe[b]) w[b*8 +: 8] = dwd[b*8 +: 8];
      shadow[idx[11:0]] = w;
    end
    if (gi || gd) m_last = gd;
    if (ir && dr && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    @(posedge clk);
    #1;
    check("rvalid", {ib.rvalid, db.rvalid}, {gi, gd});
    check("rdata_i", ib.rdata, gi ? rsp : 32'h0);
    check("rdata_d", db.rdata, gd ? rsp : 32'h0);
    check("cnt", cnt, m_cnt);
    @(negedge clk);
  endtask
  task automatic do_reset();
    ib.req = 1'b0; db.req = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; m_last = 1'b0; m_cnt = 32'h0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt_rv"}, {ib.gnt, db.gnt, ib.rvalid, db.rvalid}, 4'h0);
    check({tag, "_rdata"}, {ib.rdata, db.rdata}, 64'h0);
    check({tag, "_ram"}, {ram_en, ram_we, ram_be, ram_addr, ram_wdata}, 58'h0);
    check({tag, "_cnt"}, cnt, 32'h0);
  endtask
  initial begin
    logic [1:0]  og;
    logic [11:0] seq;
    logic        ir, dr, dwe;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;
    int          sg, rg;
    for (int i = 0; i < 4096; i++) begin
      mem[i] <= init_word(i);
      shadow[i] = init_word(i);
    end
    ib.req = 1'b0; ib.addr = 32'h0; ib.we = 1'b0; ib.be = 4'h0; ib.wdata = 32'h0;
    db.req = 1'b0; db.addr = 32'h0; db.we = 1'b0; db.be = 4'h0; db.wdata = 32'h0;
    sib.req = 1'b1; sib.addr = 32'h40; sib.we = 1'b0; sib.be = 4'h0; sib.wdata = 32'h0;
    sdb.req = 1'b0; sdb.addr = 32'h0; sdb.we = 1'b0; sdb.be = 4'h0; sdb.wdata = 32'h0;
    #2;
    rst = 1'b1;
    ib.req = 1'b1; db.req = 1'b1;
    #1;
    check_reset_outputs("reset");
    check("reset_stall_gnt", sib.gnt, 1'b0);
    do_reset();
    // stall injection against the reference LFSR
    sg = 0; rg = 0;
    for (int n = 0; n < 64; n++) begin
      #1;
      if (sib.gnt) sg++;
      if (ref_lfsr[1:0] != 2'b11) rg++;
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, og);
    end
    check("stall_count", sg, rg);
    // sustained contention from a fresh reset
    do_reset();
    seq = 12'h0;
    for (int n = 0; n < 6; n++) begin
      step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 4'hF, 32'h0, og);
      seq = {seq[9:0], og};
    end
    check("order", seq, 12'b01_10_01_10_01_10);
    check("conflict6", cnt, 32'd6);
    // instr-only back-to-back fetches
    step(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, og);
    step(1'b1, 32'h184, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, og);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, og);
    // partial write then read-back
    step(1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 4'b0011, 32'hDEAD_BEEF, og);
    step(1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 4'hF, 32'h0, og);
    check("ram_word_lo", mem[1024][15:0], 16'hBEEF);
    // word index wraps past the RAM size
    step(1'b0, 32'h0, 1'b1, 32'h0040_0000, 1'b0, 4'hF, 32'h0, og);
    step(1'b1, 32'hFFC0_0004, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, og);
    // randomized traffic, ungranted requests held stable
    ir = 1'b0; dr = 1'b0; ia = 32'h0; da = 32'h0; dwe = 1'b0; dbe = 4'h0; dwd = 32'h0;
    og = 2'b11;
    for (int n = 0; n < 400; n++) begin
      if (!ir || og[1]) begin
        ir = $urandom_range(0, 3) != 0;
        ia = $urandom & 32'hFFC0_3FFF;
      end
      if (!dr || og[0]) begin
        dr  = $urandom_range(0, 3) != 0;
        da  = $urandom & 32'hFFC0_3FFF;
        dwe = $urandom_range(0, 1) == 1;
        dbe = 4'($urandom);
        dwd = $urandom;
      end
      step(ir, ia, dr, da, dwe, dbe, dwd, og);
    end
    // reset right after a data grant drops the outstanding response
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, og);
    db.req = 1'b1; db.addr = 32'h200; db.we = 1'b0; db.be = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b1; ib.req = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    ib.req = 1'b0; db.req = 1'b0; rst = 1'b0; m_last = 1'b0; m_cnt = 32'h0;
    @(posedge clk);
    #1;
    check("post_rst_rvalid", {ib.rvalid, db.rvalid}, 2'b00);
    @(negedge clk);
    step(1'b1, 32'h300, 1'b1, 32'h304, 1'b0, 4'hF, 32'h0, og);
    check("post_rst_first", og, 2'b01);
    // counter saturation
    force dut.conflict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    repeat (3) step(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 4'hF, 32'h0, og);
    check("cnt_sat", cnt, 32'hFFFF_FFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
